// File: rtl/m72_pkg.sv
// Shared M72 types: sample ROM line cache entry layout and controller states.
package m72_pkg;

   localparam int SAMPLE_LINE_BYTES = 8;
   localparam int SAMPLE_ADDR_W     = 25;
   localparam int SAMPLE_TAG_W      = SAMPLE_ADDR_W - 3;

   typedef struct packed {
      logic [SAMPLE_TAG_W-1:0] tag;
      logic [63:0]             data;
      logic                    valid;
   } sample_line_t;

   typedef enum logic [1:0] {SYNC, IDLE, DEMAND, PREF} sample_cache_state_t;

   // Little-endian byte k of a 64-bit line.
   function automatic logic [7:0] sample_byte(input logic [63:0] d, input logic [2:0] k);
      return d[8*k +: 8];
   endfunction

endpackage

// File: rtl/sample_rom_line_cache_select.sv
// Tag compare and byte mux over the CUR and NXT sample lines (CUR wins if both hit).
module sample_line_select
   import m72_pkg::*;
#(
   parameter int TAG_W = SAMPLE_TAG_W
) (
   input  logic [TAG_W-1:0] tag_i,
   input  logic [2:0]       off_i,
   input  sample_line_t     cur_i,
   input  sample_line_t     nxt_i,
   output logic             hit_cur_o,
   output logic             hit_nxt_o,
   output logic [7:0]       byte_o
);

   assign hit_cur_o = cur_i.valid && (SAMPLE_TAG_W'(tag_i) == cur_i.tag);
   assign hit_nxt_o = nxt_i.valid && (SAMPLE_TAG_W'(tag_i) == nxt_i.tag);
   assign byte_o    = sample_byte(hit_cur_o ? cur_i.data : nxt_i.data, off_i);

endmodule

// File: rtl/sample_rom_line_cache.sv
// Byte reads from the M72 sample player turned into 8-byte SDRAM line fetches,
// with a current line and one sequential prefetch line.
module sample_rom_line_cache
   import m72_pkg::*;
#(
   parameter int ADDR_W      = 25,
   parameter int SYNC_CYCLES = 16
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              flush,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic [ADDR_W-2:0] sdr_addr,
   output logic              sdr_req,
   input  logic              sdr_ack,
   input  logic [63:0]       sdr_q
);

   localparam int TAG_W = ADDR_W - 3;
   localparam int CNT_W = $clog2(SYNC_CYCLES + 1);

   sample_cache_state_t state_q, state_d;
   sample_line_t        cur_q, cur_d, nxt_q, nxt_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                sdr_req_q, sdr_req_d;
   logic [ADDR_W-2:0]   sdr_addr_q, sdr_addr_d;
   logic [7:0]          rd_data_q, rd_data_d;
   logic                rd_valid_q, rd_valid_d;
   logic                busy_q, busy_d;
   logic                pend_q, pend_d;
   logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
   logic [2:0]          off_q, off_d;
   logic                drop_q, drop_d;

   logic              act_vld;
   logic [ADDR_W-1:0] act_addr;
   logic              hit_cur, hit_nxt;
   logic [7:0]        hit_byte;
   logic              ack_match;
   logic [TAG_W-1:0]  pf_tag, fetch_tag;

   // A fresh rd_req supersedes any pending one.
   assign act_vld   = rd_req | pend_q;
   assign act_addr  = rd_req ? rd_addr : pend_addr_q;
   assign ack_match = (sdr_ack == sdr_req_q);
   assign pf_tag    = TAG_W'(cur_q.tag) + TAG_W'(1);
   assign fetch_tag = sdr_addr_q[ADDR_W-2:2];

   sample_line_select #(.TAG_W(TAG_W)) u_sel (
      .tag_i    (act_addr[ADDR_W-1:3]),
      .off_i    (act_addr[2:0]),
      .cur_i    (cur_q),
      .nxt_i    (nxt_q),
      .hit_cur_o(hit_cur),
      .hit_nxt_o(hit_nxt),
      .byte_o   (hit_byte)
   );

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      nxt_d       = nxt_q;
      cnt_d       = cnt_q;
      sdr_req_d   = sdr_req_q;
      sdr_addr_d  = sdr_addr_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      busy_d      = busy_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      off_d       = off_q;
      drop_d      = drop_q;

      case (state_q)
         SYNC: begin
            if (cnt_q >= CNT_W'(SYNC_CYCLES - 1)) begin
               sdr_req_d = sdr_ack;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         IDLE: begin
            if (flush) begin
               state_d = IDLE;
            end else if (act_vld) begin
               pend_d = 1'b0;
               if (hit_cur || hit_nxt) begin
                  rd_data_d  = hit_byte;
                  rd_valid_d = 1'b1;
                  if (!hit_cur) begin
                     cur_d       = nxt_q;
                     nxt_d.valid = 1'b0;
                  end
               end else begin
                  sdr_addr_d = {act_addr[ADDR_W-1:3], 2'b00};
                  sdr_req_d  = ~sdr_req_q;
                  off_d      = act_addr[2:0];
                  drop_d     = 1'b0;
                  busy_d     = 1'b1;
                  state_d    = DEMAND;
               end
            end else if (cur_q.valid && !nxt_q.valid) begin
               sdr_addr_d = {pf_tag, 2'b00};
               sdr_req_d  = ~sdr_req_q;
               drop_d     = 1'b0;
               state_d    = PREF;
            end
         end

         DEMAND, PREF: begin
            if (rd_req && !flush) begin
               pend_d      = 1'b1;
               pend_addr_d = rd_addr;
            end
            if (ack_match) begin
               state_d = IDLE;
               if (state_q == DEMAND) begin
                  busy_d = 1'b0;
                  if (!(drop_q || flush)) begin
                     cur_d       = '{tag: SAMPLE_TAG_W'(fetch_tag), data: sdr_q, valid: 1'b1};
                     nxt_d.valid = 1'b0;
                     rd_data_d   = sample_byte(sdr_q, off_q);
                     rd_valid_d  = 1'b1;
                  end
               end else if (!(drop_q || flush)) begin
                  nxt_d = '{tag: SAMPLE_TAG_W'(fetch_tag), data: sdr_q, valid: 1'b1};
               end
            end
         end

         default: state_d = SYNC;
      endcase

      // Flush overrides everything above; an in-flight fetch still waits for its ack.
      if (flush) begin
         cur_d.valid = 1'b0;
         nxt_d.valid = 1'b0;
         pend_d      = 1'b0;
         if (state_q == DEMAND || state_q == PREF) drop_d = 1'b1;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q     <= SYNC;
         cur_q       <= '0;
         nxt_q       <= '0;
         cnt_q       <= '0;
         sdr_req_q   <= 1'b0;
         sdr_addr_q  <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         off_q       <= '0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         nxt_q       <= nxt_d;
         cnt_q       <= cnt_d;
         sdr_req_q   <= sdr_req_d;
         sdr_addr_q  <= sdr_addr_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         busy_q      <= busy_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         off_q       <= off_d;
         drop_q      <= drop_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign busy     = busy_q;
   assign sdr_addr = sdr_addr_q;
   assign sdr_req  = sdr_req_q;

endmodule

// File: tb/tb_sample_rom_line_cache.sv
// Bench for sample_rom_line_cache: behavioural SDRAM with a hashed ROM image, directed and random reads.
`timescale 1ns/1ps
module tb_sample_rom_line_cache;

   localparam int AW = 25;

   logic          clk_sys = 1'b0;
   logic          reset   = 1'b1;
   logic          flush   = 1'b0;
   logic          rd_req  = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [7:0]    rd_data;
   logic          rd_valid, busy;
   logic [AW-2:0] sdr_addr;
   logic          sdr_req, sdr_ack;
   logic [63:0]   sdr_q;

   int n_chk = 0;
   int n_err = 0;

   always #16 clk_sys = ~clk_sys;

   sample_rom_line_cache #(.ADDR_W(AW), .SYNC_CYCLES(16)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .flush   (flush),
      .rd_req  (rd_req),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .rd_valid(rd_valid),
      .busy    (busy),
      .sdr_addr(sdr_addr),
      .sdr_req (sdr_req),
      .sdr_ack (sdr_ack),
      .sdr_q   (sdr_q)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ROM image: line 0x20 holds bytes 01..08, every other line a hash of its address.
   function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
      logic [31:0] h;
      if (a[AW-1:3] == 22'h20) return 8'(a[2:0]) + 8'd1;
      h = 32'(a[AW-1:3]) * 32'h9E3779B1;
      return h[31:24] + 8'(a[2:0]) * 8'd37;
   endfunction

   function automatic logic [63:0] mem_line(input logic [AW-2:0] w);
      logic [63:0] d;
      for (int k = 0; k < 8; k++) d[8*k +: 8] = mem_byte({w[AW-2:2], 3'(k)});
      return d;
   endfunction

   // SDRAM: serves whenever req differs from its ack, independent of the cache reset.
   logic          ack_r    = 1'b0;
   logic [63:0]   q_r      = '0;
   bit            srv      = 1'b0;
   int            srv_cnt  = 0;
   int            lat_cfg  = 5;
   logic [AW-2:0] srv_addr = '0;
   assign sdr_ack = ack_r;
   assign sdr_q   = q_r;

   always @(posedge clk_sys) begin
      if (!srv) begin
         if (sdr_req !== ack_r) begin
            srv      <= 1'b1;
            srv_cnt  <= lat_cfg;
            srv_addr <= sdr_addr;
         end
      end else if (srv_cnt <= 1) begin
         ack_r <= ~ack_r;
         q_r   <= mem_line(srv_addr);
         srv   <= 1'b0;
      end else begin
         srv_cnt <= srv_cnt - 1;
      end
   end

   logic          prev_req   = 1'b0;
   int            n_rv       = 0;
   int            n_bad_addr = 0;
   logic [AW-2:0] tog_q[$];

   always @(negedge clk_sys) begin
      if (rd_valid) n_rv++;
      if (!reset && sdr_req !== prev_req) begin
         tog_q.push_back(sdr_addr);
         if (sdr_addr[1:0] != 2'b00) n_bad_addr++;
      end
      prev_req = sdr_req;
   end

   // One read; reports latency, ack-to-valid position and whether busy framed the wait.
   task automatic do_read(input logic [AW-1:0] a, output bit got, output int lat,
                          output int ack_lat, output logic [7:0] d, output bit busy_ok);
      bit prev_eq;
      @(negedge clk_sys);
      rd_req  = 1'b1;
      rd_addr = a;
      got     = 1'b0;
      lat     = 0;
      ack_lat = -1;
      d       = '0;
      busy_ok = 1'b1;
      prev_eq = (sdr_req == sdr_ack);
      while (!got && lat < 300) begin
         @(negedge clk_sys);
         lat++;
         rd_req = 1'b0;
         if (rd_valid) begin
            got = 1'b1;
            d   = rd_data;
            if (busy) busy_ok = 1'b0;
         end else begin
            if (!busy) busy_ok = 1'b0;
            if (ack_lat < 0 && !prev_eq && sdr_req == sdr_ack) ack_lat = lat;
            prev_eq = (sdr_req == sdr_ack);
         end
      end
      #1;
   endtask

   task automatic rd_chk(input logic [AW-1:0] a, input string tag);
      bit got, bok;
      int lat, al;
      logic [7:0] d;
      do_read(a, got, lat, al, d, bok);
      check({tag, "_resp"}, 64'(got), 64'd1);
      check({tag, "_data"}, 64'(d), 64'(mem_byte(a)));
   endtask

   task automatic pulse_flush();
      @(negedge clk_sys);
      flush = 1'b1;
      @(negedge clk_sys);
      flush = 1'b0;
   endtask

   initial begin
      bit            got, bok;
      int            lat, al, m, r0;
      logic [7:0]    d, dv;
      logic [AW-1:0] a;

      repeat (3) @(negedge clk_sys);
      check("rst_rd_data",  64'(rd_data),  64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_busy",     64'(busy),     64'd0);
      check("rst_sdr_req",  64'(sdr_req),  64'd0);
      check("rst_sdr_addr", 64'(sdr_addr), 64'd0);
      reset = 1'b0;
      repeat (20) @(negedge clk_sys);

      // Cold miss on line 0x20.
      lat_cfg = 5;
      m = tog_q.size();
      do_read(25'h000103, got, lat, al, d, bok);
      check("miss_resp",      64'(got), 64'd1);
      check("miss_data",      64'(d), 64'h04);
      check("miss_toggles",   64'(tog_q.size() - m), 64'd1);
      check("miss_word",      64'(tog_q[m]), 64'h000080);
      check("miss_ack_to_rv", 64'(lat), 64'(al + 1));
      check("miss_busy",      64'(bok), 64'd1);

      // Prefetch of the next line settles, then a CUR hit answers next cycle.
      repeat (30) @(negedge clk_sys);
      check("pref_word", 64'(tog_q[tog_q.size() - 1]), 64'h000084);
      m = tog_q.size();
      do_read(25'h000104, got, lat, al, d, bok);
      check("hit_data",    64'(d), 64'h05);
      check("hit_latency", 64'(lat), 64'd1);
      check("hit_toggles", 64'(tog_q.size() - m), 64'd0);

      // Linear playback over two lines from a cold cache.
      pulse_flush();
      repeat (5) @(negedge clk_sys);
      m = tog_q.size();
      for (int i = 0; i < 16; i++) rd_chk(25'h000100 + 25'(i), "seq");
      repeat (30) @(negedge clk_sys);
      check("seq_toggles", 64'(tog_q.size() - m), 64'd3);
      check("seq_word0",   64'(tog_q[m]),     64'h000080);
      check("seq_word1",   64'(tog_q[m + 1]), 64'h000084);
      check("seq_word2",   64'(tog_q[m + 2]), 64'h000088);

      // Two reads during a prefetch: only the later one is answered.
      lat_cfg = 12;
      m = tog_q.size();
      rd_chk(25'h000110, "nxt_hit");
      r0 = n_rv;
      @(negedge clk_sys);
      rd_req = 1'b1; rd_addr = 25'h200000;
      @(negedge clk_sys);
      rd_req = 1'b0;
      @(negedge clk_sys);
      @(negedge clk_sys);
      rd_req = 1'b1; rd_addr = 25'h300000;
      @(negedge clk_sys);
      rd_req = 1'b0;
      dv = '0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_sys);
         if (rd_valid) dv = rd_data;
      end
      #1;
      check("pend_count",    64'(n_rv - r0), 64'd1);
      check("pend_data",     64'(dv), 64'(mem_byte(25'h300000)));
      check("pend_toggles",  64'(tog_q.size() - m), 64'd3);
      check("pend_pref",     64'(tog_q[m]),     64'h00008C);
      check("pend_demand",   64'(tog_q[m + 1]), 64'h180000);
      check("pend_pref2",    64'(tog_q[m + 2]), 64'h180004);

      // Flush while a demand is in flight.
      lat_cfg = 10;
      m  = tog_q.size();
      r0 = n_rv;
      @(negedge clk_sys);
      rd_req = 1'b1; rd_addr = 25'h000050;
      @(negedge clk_sys);
      rd_req = 1'b0;
      @(negedge clk_sys);
      pulse_flush();
      repeat (30) @(negedge clk_sys);
      #1;
      check("flush_no_rv",   64'(n_rv - r0), 64'd0);
      check("flush_toggles", 64'(tog_q.size() - m), 64'd1);
      check("flush_word",    64'(tog_q[m]), 64'h000028);
      check("flush_busy",    64'(busy), 64'd0);
      m  = tog_q.size();
      r0 = n_rv;
      @(negedge clk_sys);
      flush = 1'b1; rd_req = 1'b1; rd_addr = 25'h000050;
      @(negedge clk_sys);
      flush = 1'b0; rd_req = 1'b0;
      repeat (15) @(negedge clk_sys);
      #1;
      check("flush_req_no_rv", 64'(n_rv - r0), 64'd0);
      check("flush_req_no_tg", 64'(tog_q.size() - m), 64'd0);
      m = tog_q.size();
      do_read(25'h000050, got, lat, al, d, bok);
      check("remiss_data",  64'(d), 64'(mem_byte(25'h000050)));
      check("remiss_count", 64'(tog_q.size() - m), 64'd1);
      check("remiss_word",  64'(tog_q[m]), 64'h000028);

      // Reset with a request outstanding; the SDRAM acks while reset is held.
      lat_cfg = 8;
      repeat (30) @(negedge clk_sys);
      @(negedge clk_sys);
      rd_req = 1'b1; rd_addr = 25'h400000;
      @(negedge clk_sys);
      rd_req = 1'b0;
      @(negedge clk_sys);
      check("mid_outstanding", 64'(sdr_req != sdr_ack), 64'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_req",   64'(sdr_req),  64'd0);
      check("mid_rst_busy",  64'(busy),     64'd0);
      check("mid_rst_rv",    64'(rd_valid), 64'd0);
      check("mid_rst_addr",  64'(sdr_addr), 64'd0);
      repeat (14) @(negedge clk_sys);
      reset = 1'b0;
      repeat (40) @(negedge clk_sys);
      check("resync_phase", 64'(sdr_req), 64'(sdr_ack));
      m = tog_q.size();
      do_read(25'h400000, got, lat, al, d, bok);
      check("resync_resp",    64'(got), 64'd1);
      check("resync_data",    64'(d), 64'(mem_byte(25'h400000)));
      check("resync_toggles", 64'(tog_q.size() - m), 64'd1);
      check("resync_word",    64'(tog_q[m]), 64'h200000);

      // Prefetch tag wraps past the top of the ROM region.
      lat_cfg = 4;
      repeat (20) @(negedge clk_sys);
      pulse_flush();
      m = tog_q.size();
      rd_chk(25'h1FFFFFF, "top");
      repeat (30) @(negedge clk_sys);
      check("wrap_toggles", 64'(tog_q.size() - m), 64'd2);
      check("wrap_demand",  64'(tog_q[m]),     64'hFFFFFC);
      check("wrap_pref",    64'(tog_q[m + 1]), 64'h000000);

      // Random playback: mostly linear runs with jumps, random SDRAM latency.
      a = 25'h000200;
      for (int i = 0; i < 80; i++) begin
         lat_cfg = int'($urandom_range(1, 8));
         case ($urandom_range(0, 7))
            0:       a = 25'($urandom_range(0, 1023));
            1:       a = 25'h1FFFFF0 + 25'($urandom_range(0, 15));
            default: a = a + 25'd1;
         endcase
         rd_chk(a, "rand");
      end
      repeat (20) @(negedge clk_sys);
      check("word_align", 64'(n_bad_addr), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sample_rom_line_cache.md
Name: sample_rom_line_cache

Overview:
- Sits between the M72 audio sample player and the SDRAM 64-bit sample port.
- Converts byte-granular sample reads into 8-byte line fetches over a toggle req/ack handshake.
- Holds a current line plus one sequentially prefetched line, so linear sample playback rarely stalls.
- Runs on the 32 MHz system clock.

Parameters:
- ADDR_W, 25, byte address width of the sample ROM region.
- SYNC_CYCLES, 16, cycles waited after reset release before adopting the SDRAM handshake phase.

Ports:
- clk_sys  in  1  system clock (32 MHz).
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  invalidate both lines (held high during ROM download).
- rd_req  in  1  one-cycle pulse, read one byte at rd_addr.
- rd_addr  in  ADDR_W  byte address.
- rd_data  out  8  returned byte, held until the next rd_valid.
- rd_valid  out  1  one-cycle pulse, rd_data valid.
- busy  out  1  high while a demand fetch is outstanding.
- sdr_addr  out  ADDR_W-1  SDRAM word address [ADDR_W-1:1]; bits [2:1] always 0.
- sdr_req  out  1  toggle request.
- sdr_ack  in  1  toggle ack; the request is complete when sdr_ack == sdr_req.
- sdr_q  in  64  line data, valid in the cycle sdr_ack matches sdr_req.

Behaviour:
- Reset values: rd_data=0, rd_valid=0, busy=0, sdr_req=0, sdr_addr=0, both line valid bits=0, state=SYNC.
- Line storage: two entries, CUR and NXT, each holding tag addr[ADDR_W-1:3], data[63:0] and a valid bit.
- Byte select: byte k (k=addr[2:0]) is data[8k+7:8k], little-endian.
- Hit timing: a hit in CUR or NXT gives rd_valid exactly 1 cycle after rd_req.
- Hit in NXT: NXT is promoted to CUR in the same cycle and NXT becomes invalid.
- Miss timing: rd_valid follows 1 cycle after the line arrives. busy asserts the cycle after rd_req and deasserts with rd_valid.
- SYNC: count SYNC_CYCLES, then load sdr_req<=sdr_ack and go to IDLE. This tolerates a request left outstanding by a reset that did not reset the SDRAM controller.
- IDLE, on rd_req miss:
  - sdr_addr={rd_addr[ADDR_W-1:3],2'b00}, toggle sdr_req, go to DEMAND.
- IDLE, prefetch:
  - Condition: CUR is valid, NXT is invalid and no rd_req is present.
  - Action: sdr_addr=(CUR tag+1)<<2 (word units), toggle sdr_req, go to PREF.
  - The tag increment wraps modulo 2^(ADDR_W-3).
- DEMAND, when ack matches:
  - CUR<={tag,sdr_q,valid}, NXT invalid, rd_data/rd_valid issued next cycle, go to IDLE.
- PREF, when ack matches:
  - NXT<={tag,sdr_q,valid}, go to IDLE.
- rd_req during PREF:
  - Latch it into a single pending register; a later rd_req overwrites it (last wins).
  - On prefetch completion, re-evaluate the pending request against the updated lines: hit means respond next cycle, miss means go to DEMAND.
- rd_req during DEMAND: same pending rule. The pending request is evaluated after the demand response.
- rd_valid is never issued for an overwritten request.
- No abort: the SDRAM handshake is never aborted; an issued toggle always waits for its ack.
- flush:
  - Clears both valid bits and the pending register immediately.
  - A fetch in flight completes its handshake, but its data is discarded with no valid set and no rd_valid.
  - While flush is high, rd_req is ignored and no prefetch is issued.
- rd_req and flush in the same cycle: flush wins and no response is given.
- Reset mid-fetch: all state clears asynchronously, then SYNC resynchronises the handshake phase.

Decomposition:
- m72_pkg additions:
  - SAMPLE_LINE_BYTES=8.
  - typedef sample_line_t {tag, data[63:0], valid}.
  - enum sample_cache_state_t {SYNC, IDLE, DEMAND, PREF}.
- One sub-module: sample_line_select, a combinational tag compare and byte mux over two sample_line_t entries, giving hit_cur, hit_nxt and byte.
- Everything else stays in the top of the block.

Test Plan:
- Reset, wait 16 cycles, rd_req addr 0x000103 with SDRAM ack after 6 cycles and q=0x0807060504030201 -> sdr_addr word 0x000080, rd_data=0x04, rd_valid 1 cycle after ack, busy high throughout.
- Read addr 0x000104 after the above -> CUR hit, rd_data=0x05 one cycle later, no sdr_req toggle.
- Sequential reads 0x000100..0x00010F -> exactly one prefetch issued for word 0x000084; the read at 0x000108 hits NXT; one subsequent prefetch for word 0x000088.
- rd_req 0x200000 during an outstanding prefetch, then rd_req 0x300000 before the ack -> only 0x300000 answered, via a DEMAND after the prefetch completes; 0x200000 gets no rd_valid.
- Assert flush during DEMAND -> ack consumed, no rd_valid, both lines invalid; the next read of the same address misses again.
- Assert reset while sdr_req != sdr_ack, SDRAM acks during reset -> after SYNC, sdr_req equals sdr_ack and the next miss issues exactly one toggle.
